// File: rtl/tpu_seq_pkg.sv
// Shared types and sizing helpers for the TPU tile run sequencer.
package tpu_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WPOP    = 3'd1,
    S_WRELOAD = 3'd2,
    S_RUN     = 3'd3,
    S_DONE    = 3'd4
  } seq_state_e;

  // Wide enough to reach PIPE_LAT + 2^addr_size without overflow.
  function automatic int cnt_width(input int pipe_lat, input int addr_size);
    return $clog2(pipe_lat + (1 << addr_size)) + 1;
  endfunction

endpackage

// File: rtl/tpu_addr_gen.sv
// Registered base + offset address generator; sum wraps modulo 2^AW.
module tpu_addr_gen #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] offset,
  output logic [AW-1:0] addr
);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load) addr_d = base + offset;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  assign addr = addr_q;

endmodule

// File: rtl/tpu_run_sequencer.sv
// Runs one weight-stationary tile: weight pop, array reload, UB address stream
// and result SRAM write-back, all on fixed cycle offsets from start.
module tpu_run_sequencer
  import tpu_seq_pkg::*;
#(
  parameter int ADDRESSSIZE = 10,
  parameter int MATRIX_SIZE = 128,
  parameter int PIPE_LAT    = 3 * MATRIX_SIZE
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] cfg_ub_base,
  input  logic [ADDRESSSIZE-1:0] cfg_res_base,
  input  logic [ADDRESSSIZE:0]   cfg_len,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   we_rl,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   ub_rd_valid,
  output logic                   res_we,
  output logic [ADDRESSSIZE-1:0] res_addr,
  output logic                   busy,
  output logic                   done
);

  localparam int AW = ADDRESSSIZE;
  localparam int CW = cnt_width(PIPE_LAT, ADDRESSSIZE);
  localparam logic [CW-1:0] PIPE_LAT_C = CW'(PIPE_LAT);
  localparam logic [AW-1:0] PIPE_LAT_A = AW'(PIPE_LAT);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] ub_base_q, ub_base_d;
  logic [AW-1:0] res_base_q, res_base_d;
  logic          fifo_read_enable_q, fifo_read_enable_d;
  logic          we_rl_q, we_rl_d;
  logic          ub_rd_valid_q, ub_rd_valid_d;
  logic          res_we_q, res_we_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [CW-1:0] len_ext;
  logic [CW-1:0] last_cnt;
  logic          addr_load;
  logic [AW-1:0] res_off;

  assign len_ext  = CW'(len_q);
  assign last_cnt = PIPE_LAT_C + len_ext - CW'(1);
  assign res_off  = cnt_d[AW-1:0] - PIPE_LAT_A;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    ub_base_d  = ub_base_q;
    res_base_d = res_base_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d    = S_WPOP;
          len_d      = cfg_len;
          ub_base_d  = cfg_ub_base;
          res_base_d = cfg_res_base;
        end
      end
      S_WPOP:    if (fifo_read_enable_q) state_d = S_WRELOAD;
      S_WRELOAD: begin
        cnt_d   = '0;
        state_d = (len_q == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == last_cnt) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort) state_d = S_IDLE;

    // Outputs are registered from the next state, so each strobe lands in the
    // same cycle as the state it belongs to; the pop therefore follows the
    // first non-empty sample by one clock.
    fifo_read_enable_d = (state_d == S_WPOP) && !fifo_empty;
    we_rl_d            = (state_d == S_WRELOAD);
    ub_rd_valid_d      = (state_d == S_RUN) && (cnt_d < len_ext);
    res_we_d           = (state_d == S_RUN) && (cnt_d >= PIPE_LAT_C) &&
                         (cnt_d < PIPE_LAT_C + len_ext);
    busy_d             = (state_d != S_IDLE);
    done_d             = (state_d == S_DONE);
    addr_load          = (state_d == S_RUN);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q            <= S_IDLE;
      cnt_q              <= '0;
      len_q              <= '0;
      ub_base_q          <= '0;
      res_base_q         <= '0;
      fifo_read_enable_q <= 1'b0;
      we_rl_q            <= 1'b0;
      ub_rd_valid_q      <= 1'b0;
      res_we_q           <= 1'b0;
      busy_q             <= 1'b0;
      done_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      len_q              <= len_d;
      ub_base_q          <= ub_base_d;
      res_base_q         <= res_base_d;
      fifo_read_enable_q <= fifo_read_enable_d;
      we_rl_q            <= we_rl_d;
      ub_rd_valid_q      <= ub_rd_valid_d;
      res_we_q           <= res_we_d;
      busy_q             <= busy_d;
      done_q             <= done_d;
    end
  end

  tpu_addr_gen #(.AW(AW)) u_ub_addr (
    .clk    (clk),
    .rstn   (rstn),
    .load   (addr_load),
    .base   (ub_base_q),
    .offset (cnt_d[AW-1:0]),
    .addr   (ub_addr)
  );

  tpu_addr_gen #(.AW(AW)) u_res_addr (
    .clk    (clk),
    .rstn   (rstn),
    .load   (addr_load),
    .base   (res_base_q),
    .offset (res_off),
    .addr   (res_addr)
  );

  assign fifo_read_enable = fifo_read_enable_q;
  assign we_rl            = we_rl_q;
  assign ub_rd_valid      = ub_rd_valid_q;
  assign res_we           = res_we_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: doc/tpu_run_sequencer.md
# tpu_run_sequencer

Sequencer that runs one weight-stationary tile through the TPU datapath. On a `start` pulse it:
- pops one weight set from the Weight FIFO and pulses the array's weight-reload strobe;
- streams a configured range of Unified Buffer addresses into the data-setup path;
- writes the de-skewed result rows into the result SRAM at a configured base address.

It replaces the free-running result counter and the external reload/FIFO strobes with one deterministic, cycle-accounted controller.

## Interface
Parameters:
- `ADDRESSSIZE`, 10, address width of both SRAMs.
- `MATRIX_SIZE`, 128, array dimension (informational; used for the `PIPE_LAT` default).
- `PIPE_LAT`, 3*`MATRIX_SIZE`, cycles from the first UB address issue to the first valid result row at the result SRAM input.

Ports (one clock; `rstn` asynchronous, active-low):
- `clk` in 1: clock.
- `rstn` in 1: async active-low reset.
- `start` in 1: single-cycle request, sampled only in IDLE.
- `abort` in 1: synchronous abort, any state.
- `cfg_ub_base` in `ADDRESSSIZE`: first UB row.
- `cfg_res_base` in `ADDRESSSIZE`: first result row.
- `cfg_len` in `ADDRESSSIZE`+1: rows to process, 0..2^`ADDRESSSIZE`.
- `fifo_empty` in 1: weight FIFO empty flag.
- `fifo_read_enable` out 1: one-cycle FIFO pop.
- `we_rl` out 1: one-cycle weight-reload strobe to the array.
- `ub_addr` out `ADDRESSSIZE`: UB read address.
- `ub_rd_valid` out 1: `ub_addr` carries a live row.
- `res_we` out 1: result SRAM write enable.
- `res_addr` out `ADDRESSSIZE`: result SRAM address.
- `busy` out 1: high from the cycle after accepted `start` through DONE.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, WPOP, WRELOAD, RUN, DONE.
- **IDLE:**
  - `start`=1 latches `cfg_*` into internal registers and moves to WPOP.
  - `cfg_*` changes after acceptance have no effect.
- **WPOP:**
  - Waits while `fifo_empty`=1.
  - The first cycle with `fifo_empty`=0 asserts `fifo_read_enable` for exactly that cycle and moves to WRELOAD.
- **WRELOAD:** `we_rl`=1 for one cycle; clears run counter `cnt`; moves to RUN, or to DONE if latched length is 0.
- **RUN:**
  - `cnt` increments each cycle.
  - `ub_rd_valid` = (`cnt` < len); `ub_addr` = `ub_base` + `cnt`.
  - `res_we` = (`PIPE_LAT` ≤ `cnt` < `PIPE_LAT` + len); `res_addr` = `res_base` + (`cnt` − `PIPE_LAT`).
  - When `cnt` = `PIPE_LAT` + len − 1, moves to DONE.
- **DONE:** `done`=1, `busy`=1 for one cycle, then IDLE.
- Address arithmetic is modulo 2^`ADDRESSSIZE`; base + offset wraps silently.
- `cnt` width: `$clog2(PIPE_LAT + 2^ADDRESSSIZE) + 1`; it never overflows.
- `abort`=1 in any non-IDLE state:
  - next state IDLE;
  - all strobes low in the following cycle, no `done`;
  - a FIFO pop already issued is not undone.
- `abort` and `start` together in IDLE: `abort` wins, the request is dropped.
- `start` outside IDLE is ignored, with no queueing.

## Timing
- Reset values, all outputs: `fifo_read_enable`, `we_rl`, `ub_rd_valid`, `res_we`, `busy`, `done` = 0; `ub_addr`, `res_addr` = 0; state IDLE.
- All outputs are registered, with no combinational path from inputs.
- Fixed cycle offsets (`start` accepted at T, FIFO non-empty):
  - T+1: `fifo_read_enable`.
  - T+2: `we_rl`.
  - T+3: first `ub_rd_valid`.
  - T+3+`PIPE_LAT`: first `res_we`.
  - T+3+`PIPE_LAT`+len: `done`.
- Total latency from accept to `done` is `PIPE_LAT` + len + 3 cycles, plus any FIFO-empty stall cycles.
- `ub_rd_valid` and `res_we` overlap when len > `PIPE_LAT`; both are driven the same cycle.
- Reset asserted mid-run clears everything asynchronously; the next `start` is accepted the first cycle after `rstn` deasserts.

## Structure
- Package `tpu_seq_pkg`:
  - state encoding (IDLE=0, WPOP=1, WRELOAD=2, RUN=3, DONE=4);
  - the `cnt` width function.
- Sub-module `tpu_addr_gen`: registered base + offset adder with wrap. It is instantiated twice, for the UB address and the result address.
- FSM, `cnt` and the strobe decode stay in the top module.

## Test plan
- **Basic run:** `PIPE_LAT`=8, base 0x010, res_base 0x200, len 4, FIFO non-empty.
  - Pop at T+1, `we_rl` at T+2.
  - `ub_addr` 0x010..0x013 at T+3..T+6.
  - `res_we` at T+11..T+14 with `res_addr` 0x200..0x203.
  - `done` at T+15.
- **FIFO stall:** `fifo_empty` high 5 cycles after `start` -> `fifo_read_enable` exactly once, in the first non-empty cycle; all later events shifted by 5.
- **Wrap and overlap:** base 0x3FE, len 4, `PIPE_LAT`=2 -> `ub_addr` 0x3FE, 0x3FF, 0x000, 0x001; `ub_rd_valid` and `res_we` both high at T+5, T+6.
- **Zero length:** len 0 -> `fifo_read_enable`, then `we_rl`, then `done`; no `ub_rd_valid` or `res_we` ever.
- **Abort and ignored start:**
  - `abort` in mid-RUN -> next cycle all strobes and `busy` low, no `done`.
  - `start` pulsed during RUN is ignored.
  - `start`+`abort` together in IDLE is dropped.
- **Reset mid-run:** drop `rstn` during RUN -> all outputs 0 immediately; after release a new `start` completes with correct timing.
